// File: rtl/reduce_delay_line_if.sv
// reduce_delay_line_if
//   Bundles the data/control inputs and the status outputs of
//   reduce_delay_line. The master modport drives the inputs, and the slave
//   modport is the view used by the delay line itself.
//   Signals:
//     en     advance enable (pipeline, fill, edge history and counter)
//     mode   reduce operator: 00 AND, 01 OR, 10 XOR, 11 majority
//     tap    output stage select, clamped to DEPTH-1
//     din    input word
//     clr    synchronous clear of the edge counter
//     dout   tapped pipeline stage
//     valid  tapped stage holds data loaded since reset
//     rise   rising edge on dout this cycle
//     count  saturating count of accepted rises
interface reduce_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  localparam int TAP_W = $clog2(DEPTH);

  logic             en;
  logic [1:0]       mode;
  logic [TAP_W-1:0] tap;
  logic [WIDTH-1:0] din;
  logic             clr;
  logic             dout;
  logic             valid;
  logic             rise;
  logic [CNT_W-1:0] count;

  modport master (
    output en, mode, tap, din, clr,
    input  dout, valid, rise, count
  );

  modport slave (
    input  en, mode, tap, din, clr,
    output dout, valid, rise, count
  );
endinterface

// File: rtl/reduce_delay_line.sv
// reduce_delay_line
//   Reduces a WIDTH-bit word to one bit (AND / OR / XOR / majority) and
//   pushes the result through a DEPTH-stage shift pipeline. The output comes
//   from a run-time tap. The block also tracks pipeline fill, flags rising
//   edges on the tapped output, and counts those edges in a saturating
//   counter. Everything advances only when en is high.
//   Ports:
//     clk    clock, all state updates on the rising edge
//     rst_n  synchronous active-low reset
//     bus    reduce_delay_line_if slave view (en, mode, tap, din, clr ->
//            dout, valid, rise, count)
module reduce_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reduce_delay_line_if.slave   bus
);

  localparam int TAP_W = $clog2(DEPTH);
  // The extra bit lets fill hold the value DEPTH, which can equal 2^TAP_W.
  localparam int FILL_W = TAP_W + 1;
  localparam int POP_W = $clog2(WIDTH + 1);

  localparam logic [TAP_W-1:0]  TAP_MAX  = TAP_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
  localparam logic [POP_W-1:0]  MAJ_THR  = POP_W'(WIDTH / 2);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [DEPTH-1:0]  stage_q, stage_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              prev_q, prev_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [POP_W-1:0]  ones;
  logic              red;
  logic [TAP_W-1:0]  tap_eff;
  logic              dout;
  logic              valid;
  logic              rise;

  // Reduce the input word. For even WIDTH, a tie in the majority vote gives 0.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + POP_W'(bus.din[i]);
    end
    case (bus.mode)
      2'b00:   red = &bus.din;
      2'b01:   red = |bus.din;
      2'b10:   red = ^bus.din;
      default: red = (ones > MAJ_THR);
    endcase
  end

  // Taps past the last stage can only occur when DEPTH is not a power of two.
  always_comb begin
    tap_eff = bus.tap;
    if (bus.tap > TAP_MAX) begin
      tap_eff = TAP_MAX;
    end
  end

  assign dout  = stage_q[tap_eff];
  assign valid = (fill_q > {1'b0, tap_eff});
  assign rise  = valid & dout & ~prev_q;

  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    prev_d  = prev_q;
    if (bus.en) begin
      stage_d = {stage_q[DEPTH-2:0], red};
      prev_d  = dout;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // A clear wins over a coincident rise, so that rise is dropped.
  always_comb begin
    count_d = count_q;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.en && rise && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  assign bus.dout  = dout;
  assign bus.valid = valid;
  assign bus.rise  = rise;
  assign bus.count = count_q;

endmodule

// File: tb/tb_reduce_delay_line.sv
module tb_reduce_delay_line;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] tap = 3'd0;
  logic [7:0] din = 8'h00;
  logic       clr = 1'b0;

  always #5 clk = ~clk;

  // Instance A uses the default parameters. Instance B uses DEPTH=6 and
  // CNT_W=3, which exercises tap clamping and counter saturation. Both
  // instances receive the same stimulus.
  reduce_delay_line_if ifa ();
  reduce_delay_line_if #(.DEPTH(6), .CNT_W(3)) ifb ();

  assign ifa.en   = en;
  assign ifa.mode = mode;
  assign ifa.tap  = tap;
  assign ifa.din  = din;
  assign ifa.clr  = clr;
  assign ifb.en   = en;
  assign ifb.mode = mode;
  assign ifb.tap  = tap;
  assign ifb.din  = din;
  assign ifb.clr  = clr;

  reduce_delay_line u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  reduce_delay_line #(.DEPTH(6), .CNT_W(3)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // sb holds the reduced bits, newest first. It doubles as the stage image
  // of both instances.
  bit sb[$];
  bit prev_a, prev_b;
  int cnt_a, cnt_b;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  function automatic bit ref_reduce(input logic [7:0] d, input logic [1:0] m);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    case (m)
      2'b00:   return ones == 8;
      2'b01:   return ones > 0;
      2'b10:   return (ones % 2) == 1;
      default: return ones > 4;
    endcase
  endfunction

  function automatic int tap_of(input int depth);
    return (int'(tap) > depth - 1) ? depth - 1 : int'(tap);
  endfunction

  function automatic bit exp_dout(input int depth);
    int te = tap_of(depth);
    return (sb.size() > te) ? sb[te] : 1'b0;
  endfunction

  function automatic bit exp_valid(input int depth);
    int fill = (sb.size() < depth) ? sb.size() : depth;
    return fill > tap_of(depth);
  endfunction

  function automatic bit exp_rise(input int depth, input bit prv);
    return exp_valid(depth) & exp_dout(depth) & ~prv;
  endfunction

  task automatic check_all();
    chk("a_dout",  ifa.dout,  exp_dout(8));
    chk("a_valid", ifa.valid, exp_valid(8));
    chk("a_rise",  ifa.rise,  exp_rise(8, prev_a));
    chk("a_count", ifa.count, cnt_a);
    chk("b_dout",  ifb.dout,  exp_dout(6));
    chk("b_valid", ifb.valid, exp_valid(6));
    chk("b_rise",  ifb.rise,  exp_rise(6, prev_b));
    chk("b_count", ifb.count, cnt_b);
  endtask

  task automatic model_update();
    bit ra = exp_rise(8, prev_a);
    bit rb = exp_rise(6, prev_b);
    bit da = exp_dout(8);
    bit db = exp_dout(6);
    if (!rst_n) begin
      sb.delete();
      prev_a = 0; prev_b = 0; cnt_a = 0; cnt_b = 0;
    end else begin
      if (clr) cnt_a = 0;
      else if (en && ra && cnt_a != 255) cnt_a++;
      if (clr) cnt_b = 0;
      else if (en && rb && cnt_b != 7) cnt_b++;
      if (en) begin
        prev_a = da;
        prev_b = db;
        sb.push_front(ref_reduce(din, mode));
        if (sb.size() > 8) void'(sb.pop_back());
      end
    end
  endtask

  // Check outputs on the falling edge, update the model on the rising edge,
  // then return 1 time unit after the edge so the caller can drive new inputs.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    // Test 1: reset, then a single-cycle pulse observed at tap 7.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_update();
    #1;
    cycle();
    rst_n = 1'b1; mode = 2'b00; tap = 3'd7; en = 1'b1; din = 8'hFF;
    cycle();
    din = 8'h00;
    repeat (7) cycle();
    chk("t1_dout_pulse", ifa.dout, 1);
    chk("t1_valid", ifa.valid, 1);
    chk("t1_rise", ifa.rise, 1);
    cycle();
    chk("t1_dout_after", ifa.dout, 0);
    chk("t1_count", ifa.count, 1);

    // Test 2: reduce operators at tap 0.
    tap = 3'd0;
    mode = 2'b01; din = 8'h01; cycle(); chk("t2_or",      ifa.dout, 1);
    mode = 2'b10; din = 8'h07; cycle(); chk("t2_xor",     ifa.dout, 1);
    mode = 2'b11; din = 8'h0F; cycle(); chk("t2_maj_tie", ifa.dout, 0);
    mode = 2'b11; din = 8'h1F; cycle(); chk("t2_maj",     ifa.dout, 1);
    mode = 2'b00; din = 8'hFE; cycle(); chk("t2_and",     ifa.dout, 0);

    // Test 3: enable hold at tap 3. Inputs that change while en is low are ignored.
    tap = 3'd3; mode = 2'b00;
    din = 8'hFF; cycle();
    din = 8'h00; cycle();
    din = 8'hFF; cycle();
    din = 8'hFF; cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 8'($urandom_range(0, 255));
      mode = 2'($urandom_range(0, 3));
      cycle();
    end
    chk("t3_hold_dout", ifa.dout, 1);
    en = 1'b1; mode = 2'b00; din = 8'h00;
    repeat (5) cycle();

    // Test 4: tap versus fill, and clamping on the DEPTH=6 instance.
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    tap = 3'd5; mode = 2'b00;
    din = 8'hFF; cycle();
    din = 8'h00; cycle();
    din = 8'hFF; cycle();
    chk("t4_valid_lo", ifa.valid, 0);
    tap = 3'd1;
    #1;
    chk("t4_valid_hi", ifa.valid, 1);
    chk("t4_dout_s1", ifa.dout, 0);
    cycle();
    tap = 3'd7;
    repeat (6) begin din = ~din; cycle(); end
    chk("t4_b_clamp", ifb.dout, sb[5]);
    chk("t4_b_valid", ifb.valid, 1);

    // Test 5: count up to saturation, then clear in a cycle that has a rise.
    tap = 3'd0; mode = 2'b00; din = 8'h00;
    cycle();
    for (int i = 0; i < 20; i++) begin din = ~din; cycle(); end
    chk("t5_b_sat", ifb.count, 7);
    for (int k = 0; k < 4 && !exp_rise(8, prev_a); k++) begin din = ~din; cycle(); end
    chk("t5_rise_pre", ifa.rise, 1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("t5_clr_a", ifa.count, 0);
    chk("t5_clr_b", ifb.count, 0);
    repeat (3) begin din = ~din; cycle(); end

    // Test 6: reset mid-stream, followed by a normal refill.
    tap = 3'd3;
    repeat (6) begin din = ~din; cycle(); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_valid", ifa.valid, 0);
    chk("t6_count", ifa.count, 0);
    chk("t6_dout", ifa.dout, 0);
    repeat (10) begin din = ~din; cycle(); end
    chk("t6_refill_valid", ifa.valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
